rns_mac_sequencer: RTL and testbench



---
 rtl/rns_mac_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rns_mac_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rns_mac_sequencer.sv
// Residue-domain multiply-accumulate sequencer driving a mod-129 and a mod-256 RNS ALU.
// Each accepted operand pair costs one MUL cycle and one ADD/SUB cycle into the accumulators.
module rns_mac_sequencer #(
    parameter int CNT_W   = 8,
    parameter int MAX_LEN = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a129,
    input  logic [7:0]       in_b129,
    input  logic [7:0]       in_a256,
    input  logic [7:0]       in_b256,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             alu_en,
    output logic [0:14]      alu_ctrl,
    output logic [7:0]       alu_op1_129,
    output logic [7:0]       alu_op2_129,
    output logic [7:0]       alu_op1_256,
    output logic [7:0]       alu_op2_256,
    input  logic [7:0]       alu_dout_129,
    input  logic [7:0]       alu_dout_256,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_acc129,
    output logic [7:0]       out_acc256,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc,
    output logic             out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       a129_q, b129_q, a256_q, b256_q;
    logic             sub_q, last_q;
    logic [7:0]       prod129_q, prod256_q;
    logic [7:0]       acc129_q, acc256_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;
    logic             trunc_q, err_q;
    logic             seq_end;

    assign count_inc = count_q + CNT_W'(1);
    assign seq_end   = last_q || (count_inc == CNT_W'(MAX_LEN));

    // Handshakes: a transfer happens on a clock edge where valid and ready are both 1.
    // in_ready is high only in IDLE and out_valid only in DONE, so they never overlap;
    // the result stays stable while out_valid waits for out_ready.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        alu_en      = 1'b0;
        alu_ctrl    = '0;
        alu_op1_129 = 8'd0;
        alu_op2_129 = 8'd0;
        alu_op1_256 = 8'd0;
        alu_op2_256 = 8'd0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_MUL;
            end
            S_MUL: begin
                alu_en       = 1'b1;
                alu_ctrl[14] = 1'b1;
                alu_op1_129  = a129_q;
                alu_op2_129  = b129_q;
                alu_op1_256  = a256_q;
                alu_op2_256  = b256_q;
                state_d      = S_ACC;
            end
            S_ACC: begin
                alu_en = 1'b1;
                if (sub_q) alu_ctrl[8] = 1'b1;
                else       alu_ctrl[0] = 1'b1;
                alu_op1_129 = acc129_q;
                alu_op2_129 = prod129_q;
                alu_op1_256 = acc256_q;
                alu_op2_256 = prod256_q;
                state_d     = seq_end ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q   <= S_IDLE;
            a129_q    <= 8'd0;
            b129_q    <= 8'd0;
            a256_q    <= 8'd0;
            b256_q    <= 8'd0;
            sub_q     <= 1'b0;
            last_q    <= 1'b0;
            prod129_q <= 8'd0;
            prod256_q <= 8'd0;
            acc129_q  <= 8'd0;
            acc256_q  <= 8'd0;
            count_q   <= '0;
            trunc_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a129_q <= in_a129;
                        b129_q <= in_b129;
                        a256_q <= in_a256;
                        b256_q <= in_b256;
                        sub_q  <= in_sub;
                        last_q <= in_last;
                        // Out-of-range residues are still processed; only flagged.
                        if (in_a129 >= 8'd129 || in_b129 >= 8'd129) err_q <= 1'b1;
                    end
                end
                S_MUL: begin
                    prod129_q <= alu_dout_129;
                    prod256_q <= alu_dout_256;
                end
                S_ACC: begin
                    acc129_q <= alu_dout_129;
                    acc256_q <= alu_dout_256;
                    count_q  <= count_inc;
                    if (seq_end) trunc_q <= !last_q;
                end
                S_DONE: begin
                    if (out_ready) begin
                        acc129_q <= 8'd0;
                        acc256_q <= 8'd0;
                        count_q  <= '0;
                        trunc_q  <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_acc129 = acc129_q;
    assign out_acc256 = acc256_q;
    assign out_count  = count_q;
    assign out_trunc  = trunc_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_rns_mac_sequencer.sv
// Directed bench for rns_mac_sequencer with a behavioural mod-129 / mod-256 ALU attached.
// MAX_LEN is set to 3 so truncation is reachable with short sequences.
module tb_rns_mac_sequencer;

    localparam int CNT_W   = 8;
    localparam int MAX_LEN = 3;
    localparam int W       = 26;

    logic             clk = 1'b0;
    logic             rst, clear;
    logic             in_valid, in_ready;
    logic [7:0]       in_a129, in_b129, in_a256, in_b256;
    logic             in_sub, in_last;
    logic             alu_en;
    logic [0:14]      alu_ctrl;
    logic [7:0]       alu_op1_129, alu_op2_129, alu_op1_256, alu_op2_256;
    logic [7:0]       alu_dout_129, alu_dout_256;
    logic             out_valid, out_ready;
    logic [7:0]       out_acc129, out_acc256;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc, out_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [0:14]  ctrl_mul, ctrl_add, ctrl_sub;

    rns_mac_sequencer #(.CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a129(in_a129), .in_b129(in_b129), .in_a256(in_a256), .in_b256(in_b256),
        .in_sub(in_sub), .in_last(in_last),
        .alu_en(alu_en), .alu_ctrl(alu_ctrl),
        .alu_op1_129(alu_op1_129), .alu_op2_129(alu_op2_129),
        .alu_op1_256(alu_op1_256), .alu_op2_256(alu_op2_256),
        .alu_dout_129(alu_dout_129), .alu_dout_256(alu_dout_256),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc129(out_acc129), .out_acc256(out_acc256),
        .out_count(out_count), .out_trunc(out_trunc), .out_err(out_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural RNS ALU: combinational, result in the same cycle
    always_comb begin
        alu_dout_129 = 8'd0;
        alu_dout_256 = 8'd0;
        if (alu_en) begin
            if (alu_ctrl[14]) begin
                alu_dout_129 = 8'((int'(alu_op1_129) * int'(alu_op2_129)) % 129);
                alu_dout_256 = 8'((int'(alu_op1_256) * int'(alu_op2_256)) % 256);
            end else if (alu_ctrl[8]) begin
                alu_dout_129 = 8'((int'(alu_op1_129) + 129 - (int'(alu_op2_129) % 129)) % 129);
                alu_dout_256 = 8'((int'(alu_op1_256) + 256 - int'(alu_op2_256)) % 256);
            end else if (alu_ctrl[0]) begin
                alu_dout_129 = 8'((int'(alu_op1_129) + int'(alu_op2_129)) % 129);
                alu_dout_256 = 8'((int'(alu_op1_256) + int'(alu_op2_256)) % 256);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // driver tasks (inputs change on the falling edge)
    task automatic send_pair(input logic [7:0] a129, input logic [7:0] b129,
                             input logic [7:0] a256, input logic [7:0] b256,
                             input logic sub, input logic last);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a129  = a129;
        in_b129  = b129;
        in_a256  = a256;
        in_b256  = b256;
        in_sub   = sub;
        in_last  = last;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input logic [7:0] acc129, input logic [7:0] acc256,
                                 input logic [7:0] count, input logic trunc, input logic err);
        exp_q.push_back({acc129, acc256, count, trunc, err});
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // scoreboard: compare the pending result against the queue head, then take it
    task automatic collect_result();
        logic [W-1:0] e;
        wait_out_valid();
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("out_acc129", 32'(out_acc129), 32'(e[25:18]));
        check("out_acc256", 32'(out_acc256), 32'(e[17:10]));
        check("out_count",  32'(out_count),  32'(e[9:2]));
        check("out_trunc",  32'(out_trunc),  32'(e[1]));
        check("out_err",    32'(out_err),    32'(e[0]));
        check("no_in_ready_in_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_handshake", 32'(in_ready), 32'd1);
        check("valid_drops", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] held129;
        ctrl_mul = '0; ctrl_mul[14] = 1'b1;
        ctrl_add = '0; ctrl_add[0]  = 1'b1;
        ctrl_sub = '0; ctrl_sub[8]  = 1'b1;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a129 = 8'd0; in_b129 = 8'd0; in_a256 = 8'd0; in_b256 = 8'd0;
        in_sub = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_alu_en",    32'(alu_en),     32'd0);
        check("rst_alu_ctrl",  32'(alu_ctrl),   32'd0);
        check("rst_acc129",    32'(out_acc129), 32'd0);
        check("rst_count",     32'(out_count),  32'd0);
        check("rst_trunc_err", 32'({out_trunc, out_err}), 32'd0);

        // single element with cycle-exact latency and control sequence
        send_pair(8'd10, 8'd20, 8'd10, 8'd20, 1'b0, 1'b1);
        check("mul_alu_en",   32'(alu_en),      32'd1);
        check("mul_alu_ctrl", 32'(alu_ctrl),    32'(ctrl_mul));
        check("mul_op1_129",  32'(alu_op1_129), 32'd10);
        check("mul_op2_256",  32'(alu_op2_256), 32'd20);
        check("mul_in_ready", 32'(in_ready),    32'd0);
        @(negedge clk);
        check("acc_alu_ctrl", 32'(alu_ctrl),    32'(ctrl_add));
        check("acc_op2_129",  32'(alu_op2_129), 32'd71);
        check("acc_op2_256",  32'(alu_op2_256), 32'd200);
        check("acc_no_valid", 32'(out_valid),   32'd0);
        @(negedge clk);
        check("latency_3",    32'(out_valid),   32'd1);
        check("done_alu_en",  32'(alu_en),      32'd0);
        expect_result(8'd71, 8'd200, 8'd1, 1'b0, 1'b0);
        collect_result();

        // add then subtract
        send_pair(8'd3, 8'd4, 8'd3, 8'd4, 1'b0, 1'b0);
        send_pair(8'd2, 8'd5, 8'd2, 8'd5, 1'b1, 1'b1);
        @(negedge clk);
        check("sub_alu_ctrl", 32'(alu_ctrl), 32'(ctrl_sub));
        expect_result(8'd2, 8'd2, 8'd2, 1'b0, 1'b0);
        collect_result();

        // add then add
        send_pair(8'd10, 8'd20, 8'd10, 8'd20, 1'b0, 1'b0);
        send_pair(8'd5, 8'd5, 8'd5, 8'd5, 1'b0, 1'b1);
        expect_result(8'd96, 8'd225, 8'd2, 1'b0, 1'b0);
        collect_result();

        // wrap
        send_pair(8'd128, 8'd128, 8'd128, 8'd128, 1'b0, 1'b1);
        expect_result(8'd1, 8'd0, 8'd1, 1'b0, 1'b0);
        collect_result();

        // negative result
        send_pair(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        send_pair(8'd1, 8'd1, 8'd1, 8'd1, 1'b1, 1'b1);
        expect_result(8'd128, 8'd255, 8'd2, 1'b0, 1'b0);
        collect_result();

        // backpressure: result held, new pairs refused
        send_pair(8'd4, 8'd4, 8'd4, 8'd4, 1'b0, 1'b1);
        wait_out_valid();
        held129 = out_acc129;
        in_valid = 1'b1; in_a129 = 8'd9; in_b129 = 8'd9; in_a256 = 8'd9; in_b256 = 8'd9;
        in_last = 1'b1; in_sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid),  32'd1);
            check("bp_in_ready",  32'(in_ready),   32'd0);
            check("bp_acc129",    32'(out_acc129), 32'(held129));
            check("bp_acc256",    32'(out_acc256), 32'd16);
            check("bp_count",     32'(out_count),  32'd1);
        end
        in_valid = 1'b0;
        check("bp_acc129_val", 32'(held129), 32'd16);
        expect_result(8'd16, 8'd16, 8'd1, 1'b0, 1'b0);
        collect_result();
        send_pair(8'd2, 8'd3, 8'd2, 8'd3, 1'b0, 1'b1);
        expect_result(8'd6, 8'd6, 8'd1, 1'b0, 1'b0);
        collect_result();

        // clear during ACC of the second element
        send_pair(8'd3, 8'd4, 8'd3, 8'd4, 1'b0, 1'b0);
        send_pair(8'd5, 8'd6, 8'd5, 8'd6, 1'b0, 1'b1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_in_ready",  32'(in_ready),   32'd1);
        check("clr_out_valid", 32'(out_valid),  32'd0);
        check("clr_acc129",    32'(out_acc129), 32'd0);
        check("clr_acc256",    32'(out_acc256), 32'd0);
        check("clr_count",     32'(out_count),  32'd0);
        @(negedge clk);
        check("clr_stays_idle", 32'(out_valid), 32'd0);
        send_pair(8'd1, 8'd2, 8'd1, 8'd2, 1'b0, 1'b1);
        expect_result(8'd2, 8'd2, 8'd1, 1'b0, 1'b0);
        collect_result();

        // reset while a result is pending
        send_pair(8'd7, 8'd7, 8'd7, 8'd7, 1'b0, 1'b1);
        wait_out_valid();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_done_valid", 32'(out_valid),  32'd0);
        check("rst_done_count", 32'(out_count),  32'd0);
        check("rst_done_ready", 32'(in_ready),   32'd1);

        // MAX_LEN truncation
        send_pair(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
        send_pair(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
        send_pair(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
        expect_result(8'd3, 8'd3, 8'd3, 1'b1, 1'b0);
        collect_result();

        // out-of-range mod-129 operand, then sticky flag cleared by the handshake
        send_pair(8'd200, 8'd1, 8'd200, 8'd1, 1'b0, 1'b1);
        expect_result(8'd71, 8'd200, 8'd1, 1'b0, 1'b1);
        collect_result();
        send_pair(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b1);
        expect_result(8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
        collect_result();

        // final report
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
